// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
//   Round-robin arbiter that shares one DW-bit holding register among N_REQ
//   producers. Each cycle it may pick a winner, load that producer's word into
//   the shared register and present it to a single consumer.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous flush: drops the held word and resets the pointer.
//            The register contents themselves are kept.
//   req      per-requester request. A requester holds it until it is granted
//            or until it withdraws it.
//   data     requester k's word in data[k*DW +: DW]
//   gnt      one-hot, registered, single-cycle pulse. It marks the requester
//            whose word was loaded on the previous edge.
//   q        shared register contents
//   q_owner  index of the requester that loaded q
//   q_valid  q holds an unconsumed word (state FULL)
//   q_ready  consumer accept
//   busy     equal to q_valid. It also shows the FSM state to the outside.
//
// Handshake: the word in q transfers on a rising edge where q_valid && q_ready.
//   On that same edge a pending request may reload the register, so q_valid
//   stays high for back-to-back words. While q_valid is low, q_ready is ignored.
//   Once q_valid is high, q and q_owner stay stable until the transfer happens.
//   Outputs come only from registers. req, data and q_ready affect only the
//   next state.

module dff_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DW-1:0]    data,
  output logic [N_REQ-1:0]       gnt,
  output logic [DW-1:0]          q,
  output logic [$clog2(N_REQ)-1:0] q_owner,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic                   busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     win;
  logic               any_req;
  logic               ld;

  // Round-robin search. Candidates are visited in the order ptr, ptr+1, ...,
  // wrapping modulo N_REQ. The sum uses one extra bit so ptr+i cannot
  // overflow before the wrap is applied.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_req = |req;
  // In FULL, a load is allowed only when the consumer takes the current word
  // on the same edge.
  assign ld      = any_req && ((state == EMPTY) || q_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ptr     <= '0;
      q       <= '0;
      q_owner <= '0;
      gnt     <= '0;
    end else if (clr) begin
      // The flush takes priority over a load. The held word is dropped
      // logically, but q keeps its value.
      state <= EMPTY;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      gnt <= '0;
      if (ld) begin
        q       <= data[win*DW +: DW];
        q_owner <= win;
        gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        state   <= FULL;
        ptr     <= (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
      end else if ((state == FULL) && q_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign q_valid = (state == FULL);
  assign busy    = q_valid;

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int IDW   = $clog2(N_REQ);

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       q;
  logic [IDW-1:0]      q_owner;
  logic                q_valid;
  logic                q_ready;
  logic                busy;

  int vec_count  = 0;
  int miss_count = 0;

  dff_share_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .busy    (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                           input logic [1:0] e_own, input logic e_valid);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".q"},       32'(q),       32'(e_q));
    check({tag, ".q_owner"}, 32'(q_owner), 32'(e_own));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(e_valid));
    check({tag, ".busy"},    32'(busy),    32'(e_valid));
  endtask

  logic [3:0] fair_gnt [5];
  logic [7:0] fair_q   [5];
  logic [1:0] fair_own [5];

  initial begin
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_q   = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
    fair_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n   = 1'b0;
    clr     = 1'b0;
    req     = '0;
    data    = '0;
    q_ready = 1'b0;
    #1;
    check_out("reset", 4'b0000, 8'h00, 2'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // q_ready while EMPTY has no effect
    q_ready = 1'b1;
    step();
    check_out("idle_ready", 4'b0000, 8'h00, 2'd0, 1'b0);

    // single request: one-cycle latency to gnt and q_valid
    req  = 4'b0010;
    data = {8'h44, 8'h33, 8'hA5, 8'h11};
    step();
    check_out("single", 4'b0010, 8'hA5, 2'd1, 1'b1);
    req = 4'b0000;
    step();
    check_out("single_drain", 4'b0000, 8'hA5, 2'd1, 1'b0);

    // bring the pointer back to 0, then check round-robin order and wrap
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_out("pre_fair_clr", 4'b0000, 8'hA5, 2'd1, 1'b0);
    req  = 4'b1111;
    data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("fair%0d", i), fair_gnt[i], fair_q[i], fair_own[i], 1'b1);
    end

    // backpressure; the pointer is now 1
    req = 4'b0000;
    step();
    check_out("fair_drain", 4'b0000, 8'hA0, 2'd0, 1'b0);
    req  = 4'b0010;
    data = {8'h00, 8'h77, 8'h3C, 8'h00};
    step();
    check_out("bp_load", 4'b0010, 8'h3C, 2'd1, 1'b1);
    req     = 4'b0100;
    q_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("bp_hold%0d", i), 4'b0000, 8'h3C, 2'd1, 1'b1);
    end
    q_ready = 1'b1;
    step();
    check_out("bp_release", 4'b0100, 8'h77, 2'd2, 1'b1);

    // withdraw before grant; the pointer stays at 3
    q_ready = 1'b0;
    req     = 4'b1000;
    step();
    check_out("wd_wait", 4'b0000, 8'h77, 2'd2, 1'b1);
    req     = 4'b0000;
    q_ready = 1'b1;
    step();
    check_out("wd_idle", 4'b0000, 8'h77, 2'd2, 1'b0);
    req  = 4'b1001;
    data = {8'h99, 8'h00, 8'h00, 8'h55};
    step();
    check_out("wd_ptr", 4'b1000, 8'h99, 2'd3, 1'b1);

    // flush: move the pointer to 2 first, then flush and show it restarts at 0
    req  = 4'b0010;
    data = {8'h00, 8'h00, 8'h6B, 8'h00};
    step();
    check_out("fl_pre", 4'b0010, 8'h6B, 2'd1, 1'b1);
    clr  = 1'b1;
    req  = 4'b0001;
    data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    step();
    check_out("flush", 4'b0000, 8'h6B, 2'd1, 1'b0);
    clr = 1'b0;
    req = 4'b1111;
    step();
    check_out("fl_after", 4'b0001, 8'hE0, 2'd0, 1'b1);

    // asynchronous reset in the middle of a cycle while FULL
    req = 4'b0000;
    q_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
    #2 rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
